// File: rtl/delay_line_ctrl.sv
// Access-side controller for a circular audio delay line held in a simple dual-port RAM.
// Each accepted sample is mixed with a gain-scaled delayed sample and written back.
module delay_line_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned GAIN_FRAC  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_in_valid,
  output logic                  sample_in_ready,
  input  logic [ADDR_WIDTH-1:0] delay,
  input  logic [GAIN_WIDTH-1:0] gain,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_out_valid,
  output logic                  clearing,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int unsigned ProdWidth = DATA_WIDTH + GAIN_WIDTH + 1;

  localparam logic signed [ProdWidth-1:0] SatMax =
    {{(ProdWidth - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ProdWidth-1:0] SatMin =
    {{(ProdWidth - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {StClear, StIdle, StAddr, StData, StWrite} state_e;

  state_e                  r_state;
  logic [ADDR_WIDTH:0]     r_clr_ptr;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [DATA_WIDTH-1:0]   r_sample;
  logic [GAIN_WIDTH-1:0]   r_gain;
  logic [DATA_WIDTH-1:0]   r_sample_out;
  logic                    r_sample_out_valid;
  logic                    r_ready;
  logic                    r_clearing;
  logic [ADDR_WIDTH-1:0]   r_ram_read_addr;
  logic [ADDR_WIDTH-1:0]   r_ram_write_addr;
  logic [DATA_WIDTH-1:0]   r_ram_data_in;
  logic                    r_ram_wr_en;

  logic [ADDR_WIDTH-1:0]   w_d_eff;
  logic signed [ProdWidth-1:0] w_delayed;
  logic signed [ProdWidth-1:0] w_gain;
  logic signed [ProdWidth-1:0] w_prod;
  logic signed [ProdWidth-1:0] w_fb;
  logic signed [ProdWidth-1:0] w_in;
  logic signed [ProdWidth-1:0] w_sum;
  logic [DATA_WIDTH-1:0]   w_mix;

  // A zero delay would read the slot about to be written; treat it as one sample.
  assign w_d_eff = (delay == '0) ? ADDR_WIDTH'(1) : delay;

  assign w_delayed = {{(ProdWidth - DATA_WIDTH){ram_data_out[DATA_WIDTH-1]}}, ram_data_out};
  assign w_gain    = {{(ProdWidth - GAIN_WIDTH){1'b0}}, r_gain};
  assign w_prod    = w_delayed * w_gain;
  assign w_fb      = w_prod >>> GAIN_FRAC;
  assign w_in      = {{(ProdWidth - DATA_WIDTH){r_sample[DATA_WIDTH-1]}}, r_sample};
  assign w_sum     = w_in + w_fb;

  always_comb begin
    w_mix = w_sum[DATA_WIDTH-1:0];
    if (w_sum > SatMax) begin
      w_mix = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (w_sum < SatMin) begin
      w_mix = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= StClear;
      r_clr_ptr          <= '0;
      r_wr_ptr           <= '0;
      r_sample           <= '0;
      r_gain             <= '0;
      r_sample_out       <= '0;
      r_sample_out_valid <= 1'b0;
      r_ready            <= 1'b0;
      r_clearing         <= 1'b1;
      r_ram_read_addr    <= '0;
      r_ram_write_addr   <= '0;
      r_ram_data_in      <= '0;
      r_ram_wr_en        <= 1'b0;
    end else begin
      unique case (r_state)
        StClear: begin
          // Extra pointer bit marks that every word has been issued a zero write.
          if (r_clr_ptr[ADDR_WIDTH]) begin
            r_state     <= StIdle;
            r_ram_wr_en <= 1'b0;
            r_clearing  <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_ram_wr_en      <= 1'b1;
            r_ram_data_in    <= '0;
            r_ram_write_addr <= r_clr_ptr[ADDR_WIDTH-1:0];
            r_clr_ptr        <= r_clr_ptr + 1'b1;
          end
        end
        StIdle: begin
          if (sample_in_valid && r_ready) begin
            r_sample        <= sample_in;
            r_gain          <= gain;
            r_ram_read_addr <= r_wr_ptr - w_d_eff;
            r_ready         <= 1'b0;
            r_state         <= StAddr;
          end
        end
        StAddr: begin
          r_state <= StData;
        end
        StData: begin
          r_sample_out       <= w_mix;
          r_ram_data_in      <= w_mix;
          r_sample_out_valid <= 1'b1;
          r_ram_wr_en        <= 1'b1;
          r_ram_write_addr   <= r_wr_ptr;
          r_state            <= StWrite;
        end
        StWrite: begin
          r_sample_out_valid <= 1'b0;
          r_ram_wr_en        <= 1'b0;
          r_wr_ptr           <= r_wr_ptr + 1'b1;
          r_ready            <= 1'b1;
          r_state            <= StIdle;
        end
        default: begin
          r_state <= StClear;
        end
      endcase
    end
  end

  assign sample_in_ready  = r_ready;
  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_sample_out_valid;
  assign clearing         = r_clearing;
  assign ram_read_addr    = r_ram_read_addr;
  assign ram_write_addr   = r_ram_write_addr;
  assign ram_data_in      = r_ram_data_in;
  assign ram_wr_en        = r_ram_wr_en;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Table-driven bench for delay_line_ctrl with a 16-word RAM model (registered read address).
module tb_delay_line_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int GW = 16;
  localparam int GF = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_in_valid = 1'b0;
  logic          sample_in_ready;
  logic [AW-1:0] delay = '0;
  logic [GW-1:0] gain = '0;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid;
  logic          clearing;
  logic [AW-1:0] ram_read_addr;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_wr_en;
  logic [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  delay_line_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .GAIN_WIDTH(GW),
    .GAIN_FRAC (GF)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .sample_in_ready (sample_in_ready),
    .delay           (delay),
    .gain            (gain),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .clearing        (clearing),
    .ram_read_addr   (ram_read_addr),
    .ram_write_addr  (ram_write_addr),
    .ram_data_in     (ram_data_in),
    .ram_wr_en       (ram_wr_en),
    .ram_data_out    (ram_data_out)
  );

  // RAM model; scramble fills it with non-zero junk so the zero-fill is observable.
  logic [DW-1:0] mem [16];
  logic [AW-1:0] raddr_q;
  logic          scramble = 1'b1;

  always @(posedge clk) begin
    raddr_q <= ram_read_addr;
    if (scramble) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (ram_wr_en) begin
      mem[ram_write_addr] <= ram_data_in;
    end
  end

  assign ram_data_out = mem[raddr_q];

  typedef struct {
    bit        rst_before;
    int        din;
    logic [3:0] dly;
    logic [15:0] gn;
    int        exp_out;
  } vec_t;

  vec_t vecs[$];
  vec_t echo[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_wptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input vec_t_q_sel, input bit r, input int d, input int dl, input int g,
                     input int e);
    vec_t v;
    v.rst_before = r;
    v.din        = d;
    v.dly        = dl[3:0];
    v.gn         = g[15:0];
    v.exp_out    = e;
    if (vec_t_q_sel) echo.push_back(v);
    else vecs.push_back(v);
  endtask

  task automatic reset_outputs_check();
    check("rst_sample_out", sample_out, 0);
    check("rst_out_valid", 32'(sample_out_valid), 0);
    check("rst_ready", 32'(sample_in_ready), 0);
    check("rst_clearing", 32'(clearing), 1);
    check("rst_read_addr", 32'(ram_read_addr), 0);
    check("rst_write_addr", 32'(ram_write_addr), 0);
    check("rst_data_in", ram_data_in, 0);
    check("rst_wr_en", 32'(ram_wr_en), 0);
  endtask

  // Called #1 after the edge that follows reset release.
  task automatic clear_check();
    int nwr = 0;
    int bad_addr = 0;
    int bad_data = 0;
    int bad_clr = 0;
    int nonzero = 0;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (ram_wr_en) begin
        if (32'(ram_write_addr) != nwr) bad_addr++;
        if (ram_data_in != 0) bad_data++;
        if (!clearing) bad_clr++;
        nwr++;
      end
      if (sample_in_ready) done = 1'b1;
    end
    check("clear_done", 32'(done), 1);
    check("clear_write_count", nwr, 16);
    check("clear_addr_seq_errs", bad_addr, 0);
    check("clear_data_errs", bad_data, 0);
    check("clear_flag_errs", bad_clr, 0);
    check("clear_end_clearing", 32'(clearing), 0);
    check("clear_end_wr_en", 32'(ram_wr_en), 0);
    for (int i = 0; i < 16; i++) if (mem[i] != 0) nonzero++;
    check("clear_mem_nonzero", nonzero, 0);
    exp_wptr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_outputs_check();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_check();
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!sample_in_ready && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("ready_before_accept", 32'(sample_in_ready), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int            deff;
    int            lat;
    logic [AW-1:0] exp_raddr;
    if (v.rst_before) do_reset();
    wait_ready();
    sample_in       = v.din;
    delay           = v.dly;
    gain            = v.gn;
    sample_in_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_in_valid = 1'b0;
    deff      = (v.dly == 0) ? 1 : int'(v.dly);
    exp_raddr = AW'(exp_wptr - deff);
    check("read_addr", 32'(ram_read_addr), 32'(exp_raddr));
    lat = 0;
    while (lat < 8 && !sample_out_valid) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 2);
    check("sample_out", sample_out, v.exp_out);
    check("write_addr", 32'(ram_write_addr), exp_wptr);
    check("wr_en_with_strobe", 32'(ram_wr_en), 1);
    @(posedge clk);
    #1;
    check("strobe_single_cycle", 32'(sample_out_valid), 0);
    check("sample_out_hold", sample_out, v.exp_out);
    exp_wptr = (exp_wptr + 1) % 16;
  endtask

  initial begin
    int nstrobe;
    // Impulse, delay 3, gain 0.5
    add(0, 1, 1000, 3, 'h4000, 1000);
    add(0, 0, 0, 3, 'h4000, 0);
    add(0, 0, 0, 3, 'h4000, 0);
    add(0, 0, 0, 3, 'h4000, 500);
    add(0, 0, 0, 3, 'h4000, 0);
    add(0, 0, 0, 3, 'h4000, 0);
    add(0, 0, 0, 3, 'h4000, 250);
    // Delay 0 clamps to 1
    add(0, 1, 7, 0, 'h8000, 7);
    add(0, 0, 0, 0, 'h8000, 7);
    add(0, 0, 0, 0, 'h8000, 7);
    // Positive and negative saturation
    add(0, 1, 32'h7FFF_FFF0, 1, 'h8000, 32'h7FFF_FFF0);
    add(0, 0, 32'h0000_0020, 1, 'h8000, 32'h7FFF_FFFF);
    add(0, 0, 32'h8000_0000, 1, 'h8000, 32'hFFFF_FFFF);
    add(0, 1, 32'h8000_0000, 1, 'h8000, 32'h8000_0000);
    add(0, 0, -1, 1, 'h8000, 32'h8000_0000);
    // Arithmetic shift floors: -3 * 0.5 -> -2
    add(0, 1, -3, 1, 'h4000, -3);
    add(0, 0, 0, 1, 'h4000, -2);
    // Maximum gain, then a delay change mid-stream
    add(0, 1, 1000, 1, 'hFFFF, 1000);
    add(0, 0, 0, 1, 'hFFFF, 1999);
    add(0, 0, 0, 1, 'hFFFF, 3997);
    add(0, 0, 5, 3, 'h8000, 1005);
    // Wrap-around with delay 15
    for (int k = 1; k <= 20; k++) add(0, k == 1, k, 15, 'h8000, (k <= 15) ? k : k + (k - 15));
    // Echo after a mid-transaction reset, delay 2
    add(1, 0, 800, 2, 'h4000, 800);
    add(1, 0, 0, 2, 'h4000, 0);
    add(1, 0, 0, 2, 'h4000, 400);
    add(1, 0, 0, 2, 'h4000, 0);
    add(1, 0, 0, 2, 'h4000, 200);

    repeat (2) @(posedge clk);
    #1;
    scramble = 1'b0;
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while the controller sits in DATA: the pending result must be dropped.
    wait_ready();
    sample_in       = 12345;
    delay           = 4'd1;
    gain            = 16'h8000;
    sample_in_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    reset_outputs_check();
    nstrobe = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (sample_out_valid) nstrobe++;
    end
    check("no_strobe_after_reset", nstrobe, 0);
    rst = 1'b0;
    clear_check();
    foreach (echo[i]) run_vec(echo[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
